// File: rtl/tlb_core.sv
// tlb_core: 16-entry joint MIPS32-style TLB. Each entry maps an even/odd page
// pair. Two combinational lookup ports (s0 fetch, s1 data/TLBP), a registered
// write port (TLBWI/TLBWR), a combinational read port (TLBR) and a free-running
// random replacement index for TLBWR.
//
// Handshake note: there is no valid/ready flow here. Lookups and reads are
// purely combinational in the same cycle. A write is a single-cycle strobe
// (we) sampled on the rising clock edge, and it is always accepted. Its data
// becomes visible to lookups and reads from the following cycle.
module tlb_core #(
    parameter int TLBNUM = 16,
    parameter int WIRED  = 0
) (
    input  logic        clk,
    input  logic        reset,
    // fetch-side lookup
    input  logic [18:0] s0_vpn2,
    input  logic        s0_odd_page,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_pfn,
    output logic        s0_d,
    output logic        s0_v,
    // data-side lookup / TLBP
    input  logic [18:0] s1_vpn2,
    input  logic        s1_odd_page,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_pfn,
    output logic        s1_d,
    output logic        s1_v,
    input  logic [7:0]  asid,
    // write port
    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic [26:0] w_hi,
    input  logic [24:0] w_lo0,
    input  logic [24:0] w_lo1,
    input  logic        w_g,
    // read port
    input  logic [3:0]  r_index,
    output logic [26:0] r_hi,
    output logic [24:0] r_lo0,
    output logic [24:0] r_lo1,
    output logic        r_g,
    // replacement index
    output logic [3:0]  random_index
);

    localparam logic [3:0] RAND_TOP = 4'd15;
    localparam logic [3:0] WIRED_IX = 4'(WIRED);

    // Entry storage
    logic [TLBNUM-1:0] e_q, e_d;
    logic [TLBNUM-1:0] g_q, g_d;
    logic [18:0]       vpn2_q [TLBNUM];
    logic [18:0]       vpn2_d [TLBNUM];
    logic [7:0]        asid_q [TLBNUM];
    logic [7:0]        asid_d [TLBNUM];
    logic [24:0]       lo0_q  [TLBNUM];
    logic [24:0]       lo0_d  [TLBNUM];
    logic [24:0]       lo1_q  [TLBNUM];
    logic [24:0]       lo1_d  [TLBNUM];

    logic [3:0]        rand_q, rand_d;

    logic [TLBNUM-1:0] match0, match1;

    // Next entry contents: hold, or load the addressed entry on a write strobe
    always_comb begin
        e_d = e_q;
        g_d = g_q;
        for (int i = 0; i < TLBNUM; i++) begin
            vpn2_d[i] = vpn2_q[i];
            asid_d[i] = asid_q[i];
            lo0_d[i]  = lo0_q[i];
            lo1_d[i]  = lo1_q[i];
        end
        if (we) begin
            e_d[w_index]    = 1'b1;
            g_d[w_index]    = w_g;
            vpn2_d[w_index] = w_hi[26:8];
            asid_d[w_index] = w_hi[7:0];
            lo0_d[w_index]  = w_lo0;
            lo1_d[w_index]  = w_lo1;
        end
    end

    // Entry registers; reset clears every field including the exists bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            g_q <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                lo0_q[i]  <= '0;
                lo1_q[i]  <= '0;
            end
        end else begin
            e_q <= e_d;
            g_q <= g_d;
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= vpn2_d[i];
                asid_q[i] <= asid_d[i];
                lo0_q[i]  <= lo0_d[i];
                lo1_q[i]  <= lo1_d[i];
            end
        end
    end

    // Random index walks down from 15 to WIRED and wraps back to 15
    always_comb begin
        rand_d = rand_q;
        if (WIRED_IX == RAND_TOP) begin
            rand_d = RAND_TOP;
        end else if (rand_q <= WIRED_IX) begin
            rand_d = RAND_TOP;
        end else begin
            rand_d = rand_q - 4'd1;
        end
    end

    // Random index register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rand_q <= RAND_TOP;
        end else begin
            rand_q <= rand_d;
        end
    end

    assign random_index = rand_q;

    // Per-entry match vectors; global entries ignore the ASID
    always_comb begin
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match0[i] = e_q[i] && (vpn2_q[i] == s0_vpn2) && (g_q[i] || (asid_q[i] == asid));
            match1[i] = e_q[i] && (vpn2_q[i] == s1_vpn2) && (g_q[i] || (asid_q[i] == asid));
        end
    end

    // s0 result: lowest matching index wins (scan high to low, last write wins)
    always_comb begin
        s0_found = 1'b0;
        s0_index = 4'd0;
        s0_pfn   = 20'd0;
        s0_d     = 1'b0;
        s0_v     = 1'b0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match0[i]) begin
                s0_found = 1'b1;
                s0_index = 4'(i);
                s0_pfn   = s0_odd_page ? lo1_q[i][24:5] : lo0_q[i][24:5];
                s0_d     = s0_odd_page ? lo1_q[i][1]    : lo0_q[i][1];
                s0_v     = s0_odd_page ? lo1_q[i][0]    : lo0_q[i][0];
            end
        end
    end

    // s1 result: same priority rule as s0; also serves TLBP
    always_comb begin
        s1_found = 1'b0;
        s1_index = 4'd0;
        s1_pfn   = 20'd0;
        s1_d     = 1'b0;
        s1_v     = 1'b0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match1[i]) begin
                s1_found = 1'b1;
                s1_index = 4'(i);
                s1_pfn   = s1_odd_page ? lo1_q[i][24:5] : lo0_q[i][24:5];
                s1_d     = s1_odd_page ? lo1_q[i][1]    : lo0_q[i][1];
                s1_v     = s1_odd_page ? lo1_q[i][0]    : lo0_q[i][0];
            end
        end
    end

    // TLBR read; a non-existent entry reads as all zeros
    always_comb begin
        r_hi  = 27'd0;
        r_lo0 = 25'd0;
        r_lo1 = 25'd0;
        r_g   = 1'b0;
        if (e_q[r_index]) begin
            r_hi  = {vpn2_q[r_index], asid_q[r_index]};
            r_lo0 = lo0_q[r_index];
            r_lo1 = lo1_q[r_index];
            r_g   = g_q[r_index];
        end
    end

endmodule

// File: tb/tb_tlb_core.sv
// Directed testbench for tlb_core: reset state, write/lookup latency, ASID and
// global matching, lowest-index priority, random index sequence (WIRED=0 and
// WIRED=12), invalid-page hits, asynchronous reset and reset during a write.
module tb_tlb_core;

  logic        clk;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic        s0_d, s0_v, s1_d, s1_v;
  logic [7:0]  asid;
  logic        we;
  logic [3:0]  w_index;
  logic [26:0] w_hi;
  logic [24:0] w_lo0, w_lo1;
  logic        w_g;
  logic [3:0]  r_index;
  logic [26:0] r_hi;
  logic [24:0] r_lo0, r_lo1;
  logic        r_g;
  logic [3:0]  random_index;

  // second instance, only its random counter is checked
  logic        b_s0_found, b_s1_found;
  logic [3:0]  b_s0_index, b_s1_index;
  logic [19:0] b_s0_pfn, b_s1_pfn;
  logic        b_s0_d, b_s0_v, b_s1_d, b_s1_v;
  logic [26:0] b_r_hi;
  logic [24:0] b_r_lo0, b_r_lo1;
  logic        b_r_g;
  logic [3:0]  b_random_index;

  int checks_total;
  int checks_passed;
  int checks_failed;

  tlb_core #(.TLBNUM(16), .WIRED(0)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_found(s0_found),
    .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_found(s1_found),
    .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_d(s1_d), .s1_v(s1_v),
    .asid(asid), .we(we), .w_index(w_index), .w_hi(w_hi),
    .w_lo0(w_lo0), .w_lo1(w_lo1), .w_g(w_g),
    .r_index(r_index), .r_hi(r_hi), .r_lo0(r_lo0), .r_lo1(r_lo1), .r_g(r_g),
    .random_index(random_index)
  );

  tlb_core #(.TLBNUM(16), .WIRED(12)) dut_w12 (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_found(b_s0_found),
    .s0_index(b_s0_index), .s0_pfn(b_s0_pfn), .s0_d(b_s0_d), .s0_v(b_s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_found(b_s1_found),
    .s1_index(b_s1_index), .s1_pfn(b_s1_pfn), .s1_d(b_s1_d), .s1_v(b_s1_v),
    .asid(asid), .we(1'b0), .w_index(w_index), .w_hi(w_hi),
    .w_lo0(w_lo0), .w_lo1(w_lo1), .w_g(w_g),
    .r_index(r_index), .r_hi(b_r_hi), .r_lo0(b_r_lo0), .r_lo1(b_r_lo1), .r_g(b_r_g),
    .random_index(b_random_index)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle write strobe launched on a negedge
  task automatic write_entry(input logic [3:0] idx, input logic [26:0] hi,
                             input logic [24:0] lo0, input logic [24:0] lo1, input logic g);
    @(negedge clk);
    we = 1'b1; w_index = idx; w_hi = hi; w_lo0 = lo0; w_lo1 = lo1; w_g = g;
    @(negedge clk);
    we = 1'b0;
    #1;
  endtask

  logic [3:0] exp_w12 [6];
  logic [3:0] exp_w0  [6];

  initial begin
    checks_total = 0; checks_passed = 0; checks_failed = 0;
    exp_w12 = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15, 4'd14};
    exp_w0  = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10};
    reset = 1'b1;
    s0_vpn2 = '0; s0_odd_page = 1'b0; s1_vpn2 = '0; s1_odd_page = 1'b0;
    asid = '0; we = 1'b0; w_index = '0; w_hi = '0; w_lo0 = '0; w_lo1 = '0; w_g = 1'b0;
    r_index = '0;
    #12;
    @(negedge clk);
    reset = 1'b0;
    #1;

    // 1. reset state
    check("rst_s0_found", 32'(s0_found), 32'd0);
    check("rst_s1_found", 32'(s1_found), 32'd0);
    check("rst_s0_index", 32'(s0_index), 32'd0);
    check("rst_s1_pfn", 32'(s1_pfn), 32'd0);
    check("rst_r_hi", 32'(r_hi), 32'd0);
    check("rst_r_lo0", 32'(r_lo0), 32'd0);
    check("rst_r_lo1", 32'(r_lo1), 32'd0);
    check("rst_r_g", 32'(r_g), 32'd0);

    // 5. random index sequences from reset (WIRED=12 and WIRED=0)
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rand_w12_%0d", i), 32'(b_random_index), 32'(exp_w12[i]));
      check($sformatf("rand_w0_%0d", i), 32'(random_index), 32'(exp_w0[i]));
      @(negedge clk);
      #1;
    end

    // 2. write idx 3 and look it up
    s1_vpn2 = 19'h00400; s1_odd_page = 1'b1; asid = 8'h05;
    s0_vpn2 = 19'h00400; s0_odd_page = 1'b0;
    write_entry(4'd3, {19'h00400, 8'h05}, {20'h12345, 3'b000, 1'b0, 1'b1},
                {20'h6789A, 3'b000, 1'b1, 1'b1}, 1'b0);
    check("w3_s1_found", 32'(s1_found), 32'd1);
    check("w3_s1_index", 32'(s1_index), 32'd3);
    check("w3_s1_pfn", 32'(s1_pfn), 32'h6789A);
    check("w3_s1_d", 32'(s1_d), 32'd1);
    check("w3_s1_v", 32'(s1_v), 32'd1);
    check("w3_s0_pfn_even", 32'(s0_pfn), 32'h12345);
    check("w3_s0_d_even", 32'(s0_d), 32'd0);
    check("w3_s0_v_even", 32'(s0_v), 32'd1);
    r_index = 4'd3;
    #1;
    check("w3_r_hi", 32'(r_hi), 32'h0040005);
    check("w3_r_lo1", 32'(r_lo1), 32'h0CF1343);
    check("w3_r_g", 32'(r_g), 32'd0);
    asid = 8'h06;
    #1;
    check("w3_asid_miss_found", 32'(s1_found), 32'd0);
    check("w3_asid_miss_index", 32'(s1_index), 32'd0);
    check("w3_asid_miss_pfn", 32'(s1_pfn), 32'd0);

    // 3. rewrite idx 3 as global; old result holds during the write cycle
    asid = 8'hFF;
    @(negedge clk);
    we = 1'b1; w_index = 4'd3; w_hi = {19'h00400, 8'h05};
    w_lo0 = {20'h12345, 3'b000, 1'b0, 1'b1}; w_lo1 = {20'h6789A, 3'b000, 1'b1, 1'b1}; w_g = 1'b1;
    #1;
    check("g_write_cycle_found", 32'(s1_found), 32'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("g_after_found", 32'(s1_found), 32'd1);
    check("g_after_index", 32'(s1_index), 32'd3);
    check("g_after_r_g", 32'(r_g), 32'd1);

    // 4. duplicate vpn2 in idx 9 then idx 2: lowest index wins
    asid = 8'h01; s1_vpn2 = 19'h01000; s1_odd_page = 1'b0;
    write_entry(4'd9, {19'h01000, 8'h01}, {20'hAAAAA, 3'b000, 1'b0, 1'b1}, 25'd0, 1'b0);
    check("dup_only9_index", 32'(s1_index), 32'd9);
    write_entry(4'd2, {19'h01000, 8'h01}, {20'hBBBBB, 3'b000, 1'b0, 1'b1}, 25'd0, 1'b0);
    check("dup_found", 32'(s1_found), 32'd1);
    check("dup_index", 32'(s1_index), 32'd2);
    check("dup_pfn", 32'(s1_pfn), 32'hBBBBB);

    // 6. invalid even page still hits, then async reset mid-cycle
    asid = 8'h20; s0_vpn2 = 19'h7FFFF; s0_odd_page = 1'b0;
    write_entry(4'd5, {19'h7FFFF, 8'h20}, {20'h0ABCD, 3'b000, 1'b1, 1'b0},
                {20'h11111, 3'b000, 1'b0, 1'b1}, 1'b0);
    check("inv_found", 32'(s0_found), 32'd1);
    check("inv_index", 32'(s0_index), 32'd5);
    check("inv_v", 32'(s0_v), 32'd0);
    check("inv_d", 32'(s0_d), 32'd1);
    check("inv_pfn", 32'(s0_pfn), 32'h0ABCD);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_found", 32'(s0_found), 32'd0);
    check("async_rst_pfn", 32'(s0_pfn), 32'd0);
    r_index = 4'd5;
    #1;
    check("async_rst_r_hi", 32'(r_hi), 32'd0);
    check("async_rst_rand", 32'(random_index), 32'd15);

    // reset held across a write edge: the entry stays cleared
    reset = 1'b0;
    @(negedge clk);
    we = 1'b1; w_index = 4'd7; w_hi = {19'h00123, 8'h20};
    w_lo0 = {20'h55555, 3'b000, 1'b1, 1'b1}; w_lo1 = 25'd0; w_g = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    we = 1'b0;
    reset = 1'b0;
    r_index = 4'd7; s0_vpn2 = 19'h00123;
    #1;
    check("rst_write_r_hi", 32'(r_hi), 32'd0);
    check("rst_write_found", 32'(s0_found), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/tlb_core.md
Name:
tlb_core

Overview:
Joint 16-entry MIPS32-style TLB. It is the responder for the fetch-side (s0) and data-side (s1) MMU lookup ports. It also serves the CP0 TLBWI/TLBWR write, TLBR read and TLBP probe paths. Each entry maps one even/odd page pair.

Parameters:
TLBNUM, 16, entry count; index width is 4 bits; only 16 is supported.
WIRED, 0, lowest index the random-replacement counter may produce (0..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s0_vpn2  in  19  fetch lookup VA[31:13]
s0_odd_page  in  1  fetch lookup VA[12]
s0_found  out  1  fetch hit
s0_index  out  4  index of the hitting entry
s0_pfn  out  20  selected page PFN
s0_d  out  1  selected page dirty bit
s0_v  out  1  selected page valid bit
s1_vpn2  in  19  data lookup / TLBP VA[31:13]
s1_odd_page  in  1  data lookup VA[12]
s1_found  out  1  data/probe hit
s1_index  out  4  index of the hitting entry
s1_pfn  out  20  selected page PFN
s1_d  out  1  selected page dirty bit
s1_v  out  1  selected page valid bit
asid  in  8  current ASID from EntryHi; shared by s0 and s1
we  in  1  write strobe (TLBWI/TLBWR)
w_index  in  4  entry to write
w_hi  in  27  {vpn2[18:0], asid[7:0]}
w_lo0  in  25  {pfn0[19:0], c0[2:0], d0, v0}
w_lo1  in  25  {pfn1[19:0], c1[2:0], d1, v1}
w_g  in  1  global bit (AND of EntryLo0.G and EntryLo1.G)
r_index  in  4  entry to read (TLBR)
r_hi  out  27  same packing as w_hi
r_lo0  out  25  same packing as w_lo0
r_lo1  out  25  same packing as w_lo1
r_g  out  1  stored global bit
random_index  out  4  current TLBWR replacement index

Behaviour:
- Storage: 16 entries of {e, vpn2, asid, g, lo0, lo1}. The per-entry "e" (exists) bit qualifies every match.
- Reset (asynchronous, active-high): all fields of all entries cleared, including e=0. random_index = 15.
- Write: on the rising clk edge with we=1, entry[w_index] <= {e=1, w_hi, w_g, w_lo0, w_lo1}. No write-through: the new contents become visible to search and read only from the next cycle.
- Search (combinational, same cycle): entry i matches when e_i=1, vpn2_i==sX_vpn2, and (g_i=1 or asid_i==asid). found = OR of all matches. index = matching index; with multiple matches, the lowest index wins. Page select: sX_odd_page=1 selects lo1, otherwise lo0.
- On a miss: found=0, index=0, pfn=0, d=0, v=0. A hit with v=0 still reports found=1; classifying that case as TLB-invalid belongs to the MMU.
- TLBP uses the s1 port. CP0 registers s1_found/s1_index itself.
- Read (combinational): r_* reflect entry[r_index]. An entry with e=0 reads as all zeros.
- random_index: decrements every cycle. At WIRED it wraps to 15. If WIRED=15, it holds 15.
- we affects neither the random counter nor reset state.
- Reset asserted mid-write: reset dominates; the entry is cleared.

Test Plan:
1. Reset, then any search -> s0_found=0, s1_found=0 (including vpn2=0, asid=0). r_* = 0. random_index=15.
2. Write idx 3: vpn2=0x00400, asid=0x05, g=0, pfn0=0x12345 v0=1 d0=0, pfn1=0x6789A v1=1 d1=1. Next cycle search vpn2=0x00400, asid=5, odd=1 -> found=1, index=3, pfn=0x6789A, d=1, v=1. Same search with asid=6 -> found=0.
3. Rewrite idx 3 with g=1 -> asid=0xFF hits. In the write cycle itself, the search still returns the old (non-global) result.
4. Identical vpn2 in idx 2 and idx 9 -> index=2.
5. WIRED=12, free-run for 6 cycles from reset -> random_index sequence 15,14,13,12,15,14.
6. Entry with v0=0, odd=0 lookup -> found=1, v=0, pfn=stored pfn0. Async reset pulsed mid-cycle -> found drops to 0 immediately, without waiting for a clock edge.
